des_key_sched_seq: RTL
======================

Name: des_key_sched_seq

Overview:
- Sequential DES key-schedule engine that streams the 16 round subkeys in either direction: K1..K16 for encryption, K16..K1 for decryption.
- Runs the C/D rotation both ways from a single 64-bit key load: left rotations for encrypt, right rotations for decrypt. No 16-entry subkey table is stored.
- Sits between the key register and the pipelined/iterative DES round datapath; the datapath consumes one subkey per valid/ready handshake.

Parameters:
- PARITY_CHECK, 0, 1 = check odd parity of each key byte on load; a failing key is rejected and key_err is pulsed.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to load key_in/mode; accepted only in IDLE
- key_in  input  [1:64]  DES key, FIPS 46-3 bit numbering (bit 1 = MSB), parity bits 8,16,..,64
- mode  input  1  0 = encrypt (K1 first), 1 = decrypt (K16 first); sampled with start
- abort  input  1  synchronous cancel of the current schedule
- subkey  output  [1:48]  current round subkey, PC-2 of the registered C/D
- subkey_num  output  [4:0]  DES index n (1..16) of the subkey presented; 0 when idle
- subkey_valid  output  1  subkey/subkey_num are valid
- subkey_ready  input  1  consumer accepts the subkey when high together with subkey_valid
- busy  output  1  high in RUN state
- done  output  1  one-cycle pulse after the 16th subkey handshake
- key_err  output  1  one-cycle pulse when a key is rejected on parity (PARITY_CHECK=1 only; tied 0 otherwise)

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE, C/D=0, round counter=0, subkey_valid=0, subkey_num=0, busy=0, done=0, key_err=0. subkey reads as PC-2 of zero (all 0). Reset mid-schedule discards everything; no partial output follows.
- Shift table s[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- States: IDLE, RUN.
- IDLE:
  - start=1 in cycle T: PC-1(key_in) gives C0/D0 (28b each).
  - Encrypt: C/D <= rotl(C0/D0, 1), i.e. C1/D1.
  - Decrypt: C/D <= C0/D0, which equals C16/D16.
  - Counter <= 1; go to RUN. subkey_valid=1 from T+1, so first-subkey latency is 1 cycle.
- RUN, on handshake (valid && ready) with counter j < 16:
  - Encrypt: C/D <= rotl(C/D, s[j+1]).
  - Decrypt: C/D <= rotr(C/D, s[17-j]).
  - j <= j+1.
- subkey_num: encrypt = j; decrypt = 17-j.
- Handshake at j=16: go to IDLE, subkey_valid <= 0, subkey_num <= 0, done=1 for 1 cycle.
- Back-to-back schedules: a start in the cycle done is high is accepted (state is IDLE then).
- Back-pressure: while valid && !ready, C/D, counter, subkey and subkey_num hold stable. Valid never drops without a handshake, except on abort or reset.
- start while RUN is ignored; key_in and mode changes after acceptance have no effect.
- abort: in RUN, returns to IDLE next cycle (valid=0, no done), with priority over a simultaneous handshake. In IDLE, abort has priority over start: start is ignored.
- Parity (PARITY_CHECK=1): each key byte must have odd weight. On failure at start: stay in IDLE, key_err=1 for 1 cycle, no valid.
- Arithmetic: rotations are mod 28 per half. Counter is 5 bits and never exceeds 16. subkey_num uses values 1..16 only, never 0 while valid.
- PC-1/PC-2 are the FIPS 46-3 tables, with the same bit numbering as the existing combinational subkey generator.

Test Plan:
- Encrypt, key 0x133457799BBCDFF1, ready=1: subkey_valid from cycle T+1 for 16 cycles. Round 1 gives subkey_num=1, subkey=0x1B02EFFC7072. Round 2 gives num=2, subkey=0x79AED9DBC9E5. Last gives num=16, subkey=0xCB3D8B0E17F5. done pulses one cycle after the last handshake.
- Decrypt, same key: first output num=16, 0xCB3D8B0E17F5; second num=15; last num=1, 0x1B02EFFC7072. All 16 match the encrypt sequence reversed, checked against a reference model.
- Back-pressure: ready toggled randomly (including 5 consecutive low cycles at round 7). subkey and subkey_num are held while ready=0. Exactly 16 handshakes occur, with no skip or repeat.
- Abort/restart: abort with handshake at round 9 gives valid=0 next cycle and no done. start issued while RUN at round 4 is ignored. New start after IDLE produces the full sequence from K1.
- Async reset asserted mid-RUN (round 6, between edges): all outputs go to 0 immediately. After release and start, a full correct sequence follows.
- PARITY_CHECK=1: key 0x133457799BBCDFF0 (bad last byte) gives key_err pulse, stays IDLE, no valid. Key 0x0123456789ABCDEF (odd parity) is accepted normally.

Source files
------------

// File: rtl/des_key_sched_seq.sv
// -----------------------------------------------------------------------------
// des_key_sched_seq
// Sequential DES key-schedule engine. A single 64-bit key load produces the 16
// round subkeys one per valid/ready handshake, in forward order (K1..K16, for
// encryption) or reverse order (K16..K1, for decryption). The C/D halves are
// rotated left when walking forward and right when walking backward, so no
// subkey table is kept. Bit numbering follows FIPS 46-3 (bit 1 = MSB).
// -----------------------------------------------------------------------------
module des_key_sched_seq #(
  parameter int unsigned PARITY_CHECK = 0  // 1: reject keys whose bytes lack odd parity
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:64] key_in,
  input  logic        mode,
  input  logic        abort,
  output logic [1:48] subkey,
  output logic [4:0]  subkey_num,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic        busy,
  output logic        done,
  output logic        key_err
);

  // Two-state controller; legacy-compatible encoding.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [4:0] LAST_ROUND = 5'd16;

  // ---------------------------------------------------------------------------
  // Permutation and rotation helpers
  // ---------------------------------------------------------------------------

  // Permuted Choice 1: drops the parity bits and splits the key into C0 || D0.
  function automatic logic [1:56] pc1(input logic [1:64] k);
    pc1 = {k[57], k[49], k[41], k[33], k[25], k[17], k[9],
           k[1],  k[58], k[50], k[42], k[34], k[26], k[18],
           k[10], k[2],  k[59], k[51], k[43], k[35], k[27],
           k[19], k[11], k[3],  k[60], k[52], k[44], k[36],
           k[63], k[55], k[47], k[39], k[31], k[23], k[15],
           k[7],  k[62], k[54], k[46], k[38], k[30], k[22],
           k[14], k[6],  k[61], k[53], k[45], k[37], k[29],
           k[21], k[13], k[5],  k[28], k[20], k[12], k[4]};
  endfunction

  // Permuted Choice 2: selects the 48 subkey bits from C_n || D_n.
  function automatic logic [1:48] pc2(input logic [1:56] cd);
    pc2 = {cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
           cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
           cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
           cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
           cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
           cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
           cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
           cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]};
  endfunction

  // Rotate a 28-bit half toward the MSB (bit 1) by 1 or 2 places.
  function automatic logic [1:28] rotl(input logic [1:28] h, input logic two);
    rotl = two ? {h[3:28], h[1:2]} : {h[2:28], h[1]};
  endfunction

  // Rotate a 28-bit half toward the LSB (bit 28) by 1 or 2 places.
  function automatic logic [1:28] rotr(input logic [1:28] h, input logic two);
    rotr = two ? {h[27:28], h[1:26]} : {h[28], h[1:27]};
  endfunction

  // Shift table s[n]: rounds 1, 2, 9 and 16 rotate by one, all others by two.
  function automatic logic shift_two(input logic [4:0] n);
    shift_two = !((n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16));
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]  state_q;
  logic        mode_q;      // 0 = forward (encrypt), 1 = backward (decrypt)
  logic [4:0]  cnt_q;       // round counter j, 1..16 while running
  logic [1:28] c_q;
  logic [1:28] d_q;
  logic        done_q;
  logic        key_err_q;

  // ---------------------------------------------------------------------------
  // Combinational next-step terms
  // ---------------------------------------------------------------------------
  logic [1:56] cd0;         // PC-1 of the key being loaded
  logic        parity_raw;  // every byte of key_in has odd weight
  logic        parity_ok;   // load allowed by the parity rule
  logic        enc_two;     // forward step uses s[j+1]
  logic        dec_two;     // backward step undoes s[17-j]
  logic        load;        // start accepted in IDLE (before the parity decision)

  // Derive load data, parity verdict and the rotation amount for this round.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    cd0        = pc1(key_in);
    parity_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      parity_raw = parity_raw & (^key_in[8*i+1 +: 8]);
    end
    parity_ok  = (PARITY_CHECK == 0) || parity_raw;
    enc_two    = shift_two(cnt_q + 5'd1);
    dec_two    = shift_two(5'd17 - cnt_q);
    load       = (state_q == ST_IDLE) && start && !abort;
  end

  // Controller: load, step on handshake, finish after round 16, abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      cnt_q     <= 5'd0;
      done_q    <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      // NOTE: all registered state uses non-blocking assignments so every
      // flop samples pre-edge values regardless of statement order.
      done_q    <= 1'b0;
      key_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            if (parity_ok) begin
              mode_q  <= mode;
              cnt_q   <= 5'd1;
              state_q <= ST_RUN;
            end else begin
              key_err_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            // Abort wins over a simultaneous handshake: no done pulse.
            cnt_q   <= 5'd0;
            state_q <= ST_IDLE;
          end else if (subkey_ready) begin
            if (cnt_q == LAST_ROUND) begin
              cnt_q   <= 5'd0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // C/D datapath: PC-1 load on accept, one rotation per non-final handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: C/D are ordinary registers, not a stored table, so they are
      // reset; this makes subkey read as PC-2 of zero while in reset.
      c_q <= '0;
      d_q <= '0;
    end else if (load && parity_ok) begin
      if (mode) begin
        // C0/D0 equals C16/D16 (total rotation is 28), the first backward key.
        c_q <= cd0[1:28];
        d_q <= cd0[29:56];
      end else begin
        c_q <= rotl(cd0[1:28], 1'b0);
        d_q <= rotl(cd0[29:56], 1'b0);
      end
    end else if ((state_q == ST_RUN) && !abort && subkey_ready &&
                 (cnt_q != LAST_ROUND)) begin
      if (mode_q) begin
        c_q <= rotr(c_q, dec_two);
        d_q <= rotr(d_q, dec_two);
      end else begin
        c_q <= rotl(c_q, enc_two);
        d_q <= rotl(d_q, enc_two);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registered state, so they clear with rst_n.
  // ---------------------------------------------------------------------------
  assign busy         = (state_q == ST_RUN);
  assign subkey_valid = busy;
  assign subkey_num   = busy ? (mode_q ? (5'd17 - cnt_q) : cnt_q) : 5'd0;
  assign subkey       = pc2({c_q, d_q});
  assign done         = done_q;
  assign key_err      = key_err_q;

endmodule
